// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the P5 fetch stage: widths, reset defaults, FSM states, npc helper.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;

  // MARS text base and the canonical NOP (sll $0,$0,0)
  localparam logic [INSTR_W-1:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

  // Next fetch PC: word-aligned redirect target when taken, else sequential (wraps mod 2^32)
  function automatic logic [INSTR_W-1:0] next_pc(input logic [INSTR_W-1:0] pc,
                                                 input logic redirect_valid,
                                                 input logic [INSTR_W-1:0] redirect_pc);
    if (redirect_valid) begin
      return redirect_pc & ~32'h3;
    end
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [INSTR_W-1:0] load_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc,
  output logic               valid
);

  // Load has priority over bubble; a bubble keeps pc so pc_d stays meaningful for debug
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the P5 MIPS core: fetch PC, imem req/ready handshake, stall hold buffer,
// delay-slot-aware redirect, feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_d,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] instr_d,
  output logic [INSTR_W-1:0] pc_d,
  output logic               valid_d
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] hold_q;

  logic               advance;
  logic               bubble;
  logic [INSTR_W-1:0] adv_word;
  logic [INSTR_W-1:0] npc;

  // Advance/bubble decode; redirect only matters through npc, which is used only on advance
  always_comb begin
    advance  = !stall_d && ((state_q == StFetch && imem_ready) || state_q == StHold);
    bubble   = !stall_d && state_q == StFetch && !imem_ready;
    adv_word = (state_q == StHold) ? hold_q : imem_rdata;
    npc      = next_pc(pc_q, redirect_valid, redirect_pc);
    imem_req  = (state_q == StFetch);
    imem_addr = pc_q;
  end

  // Fetch FSM, fetch PC and the word parked while Decode is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (imem_ready && stall_d) begin
            hold_q  <= imem_rdata;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (!stall_d) state_q <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
      if (advance) pc_q <= npc;
    end
  end

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (advance),
    .bubble     (bubble),
    .load_instr (adv_word),
    .load_pc    (pc_q),
    .instr      (instr_d),
    .pc         (pc_d),
    .valid      (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked against a
// transaction-level model (one pending fetch, optional parked word, IF/ID contents).
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;

  int vectors = 0;
  int errs    = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_parked;
  logic [31:0] m_park_word;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_valid;

  fetch_stage #(
    .RESET_PC  (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .valid_d        (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_started = 1'b0; m_parked = 1'b0; m_park_word = '0;
    m_instr = '0; m_pcd = '0; m_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w);
    m_instr = w; m_pcd = m_pc; m_valid = 1'b1;
    m_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : m_pc + 32'd4;
  endtask

  // One clock: drive inputs, check request side, clock, update model, check IF/ID
  task automatic step(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc);
    logic outstanding;
    imem_ready = rdy; stall_d = stl; redirect_valid = rv; redirect_pc = rpc;
    imem_rdata = mem_word(m_pc);
    outstanding = m_started && !m_parked;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, outstanding});
    if (outstanding) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    if (outstanding) begin
      if (rdy && !stl) deliver(mem_word(m_pc));
      else if (rdy) begin m_parked = 1'b1; m_park_word = mem_word(m_pc); end
      else if (!stl) begin m_instr = 32'h0; m_valid = 1'b0; end
    end else if (m_parked && !stl) begin
      deliver(m_park_word);
      m_parked = 1'b0;
    end
    m_started = 1'b1;
    @(negedge clk);
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pcd);
    chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall_d = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pc_d", pc_d, 32'h0);
    rst_n = 1'b1;

    // 0-wait fetch from reset
    step(1, 0, 0, 0);                       // idle cycle, no request
    step(1, 0, 0, 0);                       // 0x3000
    chk("first_pc_d", pc_d, 32'h0000_3000);
    // imem wait states at 0x3004
    repeat (3) begin
      step(0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h0000_3004);
    end
    step(1, 0, 0, 0);
    chk("after_wait_pc_d", pc_d, 32'h0000_3004);
    // stall on ready of 0x3008: word parked, IF/ID held
    step(1, 1, 0, 0);
    chk("stall_keep_pc_d", pc_d, 32'h0000_3004);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("unpark_pc_d", pc_d, 32'h0000_3008);
    chk("unpark_instr", instr_d, mem_word(32'h0000_3008));
    step(1, 0, 0, 0);                       // 0x300C
    step(1, 0, 0, 0);                       // 0x3010 = beq now in D
    // taken branch held across a two-cycle stall; delay slot 0x3014 still issues
    step(1, 1, 1, 32'h0000_3101);
    step(0, 1, 1, 32'h0000_3101);
    step(0, 0, 1, 32'h0000_3101);
    chk("delay_slot_pc_d", pc_d, 32'h0000_3014);
    step(0, 0, 1, 32'h0000_BEEC);           // redirect ignored: no advance
    step(1, 0, 0, 0);
    chk("target_pc_d", pc_d, 32'h0000_3100);
    // jump to 0x3020, then reset in the middle of a wait there
    step(1, 0, 1, 32'h0000_3020);
    step(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, valid_d}, 32'd0);
    chk("async_rst_pc_d", pc_d, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("restart_pc_d", pc_d, 32'h0000_3000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
